// File: rtl/mem_port_arb_pkg.sv
// Shared RAM command codes, arbiter state encoding and requester ids for the memory port arbiter.
package mem_port_arb_pkg;

  localparam logic [1:0] RAM_NONE  = 2'd0;
  localparam logic [1:0] RAM_READ  = 2'd1;
  localparam logic [1:0] RAM_WRITE = 2'd2;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_RWAIT = 2'd1;
  localparam logic [1:0] ARB_RESP  = 2'd2;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  // Context captured at grant; requesters may move their address/data afterwards.
  typedef struct packed {
    logic id;
    logic we;
    logic hsel;
  } req_lat_t;

  function automatic logic [15:0] half_sel(input logic [31:0] word, input logic hi);
    return hi ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/mem_port_arb_starve_pick.sv
// Picks fetch or data for the shared port; data wins unless fetch has been starved MAX_DBURST times.
// Latency: combinational winner, counter updates on the grant edge.
// Backpressure: grant_en low suppresses both wins and freezes the counter.
module mem_port_arb_starve_pick #(
  parameter int MAX_DBURST = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic grant_en,
  input  logic if_req,
  input  logic d_req,
  output logic if_win,
  output logic d_win
);

  logic [3:0] starve_cnt;
  logic       force_if;

  assign force_if = (starve_cnt == 4'(MAX_DBURST));
  assign d_win    = grant_en && d_req && !(if_req && force_if);
  assign if_win   = grant_en && if_req && !d_win;

  // Only data grants that actually make fetch wait count toward starvation.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      starve_cnt <= '0;
    end else if (if_win || (d_win && !if_req)) begin
      starve_cnt <= '0;
    end else if (d_win && !force_if) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/mem_port_arb.sv
// Shares one clocked RAM port between instruction fetch and load/store.
// Latency: grant and RAM command same cycle; read data valid RD_LAT+1 cycles after grant.
// Backpressure: no grants while a read is outstanding; requesters hold req until gnt.
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int MAX_DBURST = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [15:0] o_if_rdata,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  output logic        o_d_gnt,
  output logic        o_d_rvalid,
  output logic [31:0] o_d_rdata,
  output logic [1:0]  o_ram_do,
  output logic [31:0] o_ram_addr,
  output logic [31:0] o_ram_val,
  input  logic [31:0] i_ram_val,
  output logic        o_busy
);

  logic [1:0] state;
  logic [2:0] lat_cnt;
  req_lat_t   lat;
  logic       grant_en;
  logic       if_win;
  logic       d_win;

  // Gating with reset keeps grants low while reset is held.
  assign grant_en = i_rst && (state != ARB_RWAIT);

  mem_port_arb_starve_pick #(
    .MAX_DBURST(MAX_DBURST)
  ) u_pick (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .grant_en(grant_en),
    .if_req  (i_if_req),
    .d_req   (i_d_req),
    .if_win  (if_win),
    .d_win   (d_win)
  );

  assign o_if_gnt    = if_win;
  assign o_d_gnt     = d_win;
  assign o_busy      = (state == ARB_RWAIT);
  assign o_if_rvalid = (state == ARB_RESP) && (lat.id == REQ_IF);
  assign o_d_rvalid  = (state == ARB_RESP) && (lat.id == REQ_D) && !lat.we;

  always_comb begin
    o_ram_do   = RAM_NONE;
    o_ram_addr = '0;
    o_ram_val  = '0;
    if (d_win) begin
      o_ram_do   = i_d_we ? RAM_WRITE : RAM_READ;
      o_ram_addr = i_d_addr;
      o_ram_val  = i_d_wdata;
    end else if (if_win) begin
      o_ram_do   = RAM_READ;
      o_ram_addr = i_if_addr;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= ARB_IDLE;
      lat_cnt    <= '0;
      lat        <= '0;
      o_if_rdata <= '0;
      o_d_rdata  <= '0;
    end else begin
      case (state)
        ARB_RWAIT: begin
          if (lat_cnt == 3'(RD_LAT)) begin
            state <= ARB_RESP;
            if (lat.id == REQ_IF) o_if_rdata <= half_sel(i_ram_val, lat.hsel);
            else                  o_d_rdata  <= i_ram_val;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        default: begin
          // IDLE and RESP both accept a new grant; writes complete in the grant cycle.
          if (d_win || if_win) begin
            lat.id   <= d_win ? REQ_D : REQ_IF;
            lat.we   <= d_win && i_d_we;
            lat.hsel <= i_if_addr[1];
          end
          if (if_win || (d_win && !i_d_we)) begin
            state   <= ARB_RWAIT;
            lat_cnt <= 3'd1;
          end else begin
            state <= ARB_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: directed scenarios plus random traffic against a cycle-level reference model.
module tb_mem_port_arb;
  import mem_port_arb_pkg::*;

  localparam int RD_LAT     = 2;
  localparam int MAX_DBURST = 4;

  logic        i_clk;
  logic        i_rst;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt;
  logic        o_if_rvalid;
  logic [15:0] o_if_rdata;
  logic        i_d_req;
  logic        i_d_we;
  logic [31:0] i_d_addr;
  logic [31:0] i_d_wdata;
  logic        o_d_gnt;
  logic        o_d_rvalid;
  logic [31:0] o_d_rdata;
  logic [1:0]  o_ram_do;
  logic [31:0] o_ram_addr;
  logic [31:0] o_ram_val;
  logic [31:0] i_ram_val;
  logic        o_busy;

  mem_port_arb #(.RD_LAT(RD_LAT), .MAX_DBURST(MAX_DBURST)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
    .o_d_gnt(o_d_gnt), .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata),
    .o_ram_do(o_ram_do), .o_ram_addr(o_ram_addr), .o_ram_val(o_ram_val),
    .i_ram_val(i_ram_val), .o_busy(o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'hBEEF1234 ^ (32'(i) * 32'h9E3779B9);
  endfunction

  // Clocked RAM with RD_LAT-deep read pipeline; junk on the bus when no read is in flight.
  logic [31:0] mem [64];
  logic [31:0] rd_pipe [RD_LAT];
  int          n_ram_ops = 0;

  always @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (o_ram_do == RAM_WRITE) begin
      mem[o_ram_addr[7:2]] <= o_ram_val;
    end
    if (o_ram_do != RAM_NONE) n_ram_ops <= n_ram_ops + 1;
    rd_pipe[0] <= (o_ram_do == RAM_READ) ? mem[o_ram_addr[7:2]] : $urandom;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign i_ram_val = rd_pipe[RD_LAT-1];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: tracks when the port is free, fetch starvation and pending responses.
  typedef struct {
    int          due;
    logic        id;
    logic [31:0] dat;
  } resp_t;

  int          cyc;
  int          next_ok;
  int          busy_until;
  int          streak;
  logic [15:0] exp_if_rdata;
  logic [31:0] exp_d_rdata;
  logic [31:0] ref_mem [64];
  resp_t       resp_q [$];
  bit          g_if;
  bit          g_d;

  task automatic model_reset();
    resp_q.delete();
    streak       = 0;
    next_ok      = 0;
    busy_until   = -1;
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
  endtask

  task automatic model_check();
    bit          can, ei, ed, exp_ifv, exp_dv;
    logic [1:0]  edo;
    logic [31:0] a, w;
    resp_t       r;
    can = (i_rst === 1'b1) && (cyc >= next_ok);
    ed  = can && i_d_req && !(i_if_req && streak == MAX_DBURST);
    ei  = can && i_if_req && !ed;
    edo = ed ? (i_d_we ? RAM_WRITE : RAM_READ) : (ei ? RAM_READ : RAM_NONE);
    check("if_gnt", o_if_gnt, ei);
    check("d_gnt", o_d_gnt, ed);
    check("ram_do", o_ram_do, edo);
    if (ed) check("ram_addr_d", o_ram_addr, i_d_addr);
    else if (ei) check("ram_addr_if", o_ram_addr, i_if_addr);
    if (ed && i_d_we) check("ram_wdata", o_ram_val, i_d_wdata);
    check("busy", o_busy, cyc <= busy_until);
    exp_ifv = 0;
    exp_dv  = 0;
    if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
      r = resp_q.pop_front();
      if (r.id == REQ_IF) begin exp_ifv = 1; exp_if_rdata = r.dat[15:0]; end
      else begin exp_dv = 1; exp_d_rdata = r.dat; end
    end
    check("if_rvalid", o_if_rvalid, exp_ifv);
    check("d_rvalid", o_d_rvalid, exp_dv);
    check("if_rdata", o_if_rdata, exp_if_rdata);
    check("d_rdata", o_d_rdata, exp_d_rdata);
    if (ed) streak = i_if_req ? ((streak < MAX_DBURST) ? streak + 1 : streak) : 0;
    if (ei) streak = 0;
    if (ed && i_d_we) begin
      ref_mem[i_d_addr[7:2]] = i_d_wdata;
      next_ok = cyc + 1;
    end else if (ed || ei) begin
      a     = ed ? i_d_addr : i_if_addr;
      w     = ref_mem[a[7:2]];
      r.id  = ed ? REQ_D : REQ_IF;
      r.due = cyc + RD_LAT + 1;
      r.dat = ed ? w : ((i_if_addr[1] ? (w >> 16) : w) & 32'h0000FFFF);
      resp_q.push_back(r);
      next_ok    = r.due;
      busy_until = cyc + RD_LAT;
    end
    g_if = ei;
    g_d  = ed;
  endtask

  task automatic cycle_end();
    @(negedge i_clk);
    model_check();
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] rand_if_addr();
    return {24'b0, 7'($urandom), 1'b0};
  endfunction

  function automatic logic [31:0] rand_d_addr();
    return {24'b0, 6'($urandom), 2'b0};
  endfunction

  task automatic do_req(input bit is_if, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, output int tg);
    tg = -1;
    if (is_if) begin i_if_req = 1; i_if_addr = addr; end
    else begin i_d_req = 1; i_d_we = we; i_d_addr = addr; i_d_wdata = wd; end
    for (int k = 0; k < 64 && tg < 0; k++) begin
      cycle_end();
      if (is_if ? g_if : g_d) tg = cyc - 1;
    end
    if (is_if) begin i_if_req = 0; i_if_addr = $urandom; end
    else begin i_d_req = 0; i_d_addr = $urandom; i_d_wdata = $urandom; end
    if (tg < 0) check("gnt_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit idle = 0;
    for (int k = 0; k < 64 && !idle; k++) begin
      if (resp_q.size() == 0 && cyc >= next_ok) idle = 1;
      else cycle_end();
    end
    check("idle_timeout", idle, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t1, t2, ops0;
    int order [$];
    int gcyc [$];
    i_rst = 0; i_if_req = 0; i_if_addr = 0; i_d_req = 0; i_d_we = 0;
    i_d_addr = 0; i_d_wdata = 0; cyc = 0;
    model_reset();
    repeat (3) cycle_end();
    check("rst_ram_do", o_ram_do, RAM_NONE);
    check("rst_ram_addr", o_ram_addr, 0);
    check("rst_ram_val", o_ram_val, 0);
    check("rst_busy", o_busy, 0);
    i_rst = 1;

    do_req(1, 0, 32'h2, 0, t1);
    wait_idle();
    check("fetch_hw_0x02", o_if_rdata, 16'hBEEF);

    do_req(0, 1, 32'h10, 32'hCAFEF00D, t1);
    do_req(0, 1, 32'h14, 32'h12345678, t2);
    check("store_b2b_gap", t2 - t1, 1);
    wait_idle();
    do_req(0, 0, 32'h10, 0, t1);
    wait_idle();
    check("load_after_store", o_d_rdata, 32'hCAFEF00D);

    i_if_req = 1; i_if_addr = rand_if_addr();
    i_d_req = 1; i_d_we = 0; i_d_addr = rand_d_addr();
    for (int k = 0; k < 12 * (RD_LAT + 1) + 4 && order.size() < 10; k++) begin
      cycle_end();
      if (g_if) begin order.push_back(0); gcyc.push_back(cyc - 1); i_if_addr = rand_if_addr(); end
      if (g_d) begin order.push_back(1); gcyc.push_back(cyc - 1); i_d_addr = rand_d_addr(); end
    end
    i_if_req = 0; i_d_req = 0;
    check("burst_count", order.size(), 10);
    foreach (order[k])
      check($sformatf("burst_order%0d", k), order[k], ((k % (MAX_DBURST + 1)) == MAX_DBURST) ? 0 : 1);
    for (int k = 1; k < gcyc.size(); k++)
      check($sformatf("read_spacing%0d", k), gcyc[k] - gcyc[k-1], RD_LAT + 1);
    wait_idle();

    do_req(0, 0, 32'h20, 0, t1);
    i_rst = 0; i_d_req = 1; i_d_we = 0; i_d_addr = 32'h24;
    #1;
    model_reset();
    check("arst_busy", o_busy, 0);
    check("arst_d_gnt", o_d_gnt, 0);
    check("arst_ram_do", o_ram_do, RAM_NONE);
    check("arst_d_rdata", o_d_rdata, 0);
    check("arst_if_rdata", o_if_rdata, 0);
    repeat (RD_LAT + 2) cycle_end();
    i_rst = 1;
    do_req(0, 0, 32'h24, 0, t1);
    wait_idle();
    check("load_after_rst", o_d_rdata, init_word(9));

    ops0 = n_ram_ops;
    do_req(0, 0, 32'h30, 0, t1);
    i_if_req = 1; i_if_addr = 32'h6;
    cycle_end();
    i_if_req = 0;
    wait_idle();
    check("withdraw_ram_ops", n_ram_ops - ops0, 1);

    for (int k = 0; k < 800; k++) begin
      if (!i_if_req) begin
        if ($urandom_range(3) == 0) begin i_if_req = 1; i_if_addr = rand_if_addr(); end
      end else if ($urandom_range(9) == 0) i_if_req = 0;
      if (!i_d_req) begin
        if ($urandom_range(2) == 0) begin
          i_d_req = 1; i_d_we = 1'($urandom); i_d_addr = rand_d_addr(); i_d_wdata = $urandom;
        end
      end else if ($urandom_range(9) == 0) i_d_req = 0;
      cycle_end();
      if (g_if) begin i_if_req = 0; i_if_addr = rand_if_addr(); end
      if (g_d) begin i_d_req = 0; i_d_addr = rand_d_addr(); i_d_wdata = $urandom; end
    end
    i_if_req = 0; i_d_req = 0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arb.md
Name: mem_port_arb

Overview:
- Shares the single clocked RAM port between instruction fetch (PC-driven, 16-bit instructions) and the load/store path (LD/LDA read, ST write).
- Sits between the proc datapath and the ram module, replacing the direct ram_do/ram_addr muxing in proc.
- Arbitrates requests, sequences RAM read latency and returns read data with a one-cycle valid pulse per requester.
- Guarantees fetch forward progress under continuous data traffic.

Parameters:
- RD_LAT, 1: RAM read latency in cycles from the ram_do=READ cycle to valid i_ram_val; legal range 1..7.
- MAX_DBURST, 4: maximum consecutive data grants while fetch is pending before fetch is forced; legal range 1..15.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-low.
- i_if_req  in  1  fetch request; held until o_if_gnt.
- i_if_addr  in  32  fetch byte address, halfword aligned.
- o_if_gnt  out  1  fetch grant; combinational, same cycle as the accepted request.
- o_if_rvalid  out  1  fetch data valid; 1-cycle pulse.
- o_if_rdata  out  16  fetched instruction; registered, held until the next o_if_rvalid.
- i_d_req  in  1  data request; held until o_d_gnt.
- i_d_we  in  1  1 = write (ST), 0 = read (LD/LDA).
- i_d_addr  in  32  data byte address, word aligned.
- i_d_wdata  in  32  store data.
- o_d_gnt  out  1  data grant; combinational.
- o_d_rvalid  out  1  load data valid; 1-cycle pulse, reads only.
- o_d_rdata  out  32  load data; registered, held.
- o_ram_do  out  2  RAM_NONE / RAM_READ / RAM_WRITE.
- o_ram_addr  out  32  RAM address.
- o_ram_val  out  32  RAM write data.
- i_ram_val  in  32  RAM read data.
- o_busy  out  1  high while a read is outstanding.

Behaviour:
- Reset (i_rst=0, any time):
  - state IDLE, starve counter 0.
  - All gnt/rvalid/busy 0, o_ram_do=RAM_NONE, o_ram_addr/o_ram_val/o_*_rdata = 0.
  - Reset during an outstanding read drops it: no rvalid is ever produced and the requester reissues.
- States:
  - IDLE: accepts a request.
  - RWAIT: read outstanding, counter counts 1..RD_LAT.
  - RESP: capture cycle; behaves as IDLE for new grants.
- Grant:
  - Issued only in IDLE or RESP.
  - In the grant cycle T, o_ram_do/o_ram_addr/o_ram_val are driven combinationally from the granted request.
  - Otherwise o_ram_do=RAM_NONE; o_ram_addr and o_ram_val are don't-care but stable.
- Arbitration, both requests in the same cycle:
  - Data wins unless the starve counter equals MAX_DBURST; in that case fetch wins.
  - Counter increments (saturating) on each data grant made while i_if_req=1.
  - Counter clears on any fetch grant, and on a data grant made while i_if_req=0.
- Write (i_d_we=1):
  - Single cycle, RAM_WRITE at T.
  - State stays or returns to IDLE; a new grant is allowed at T+1. No rvalid.
- Read:
  - RAM_READ at T, then RWAIT for RD_LAT cycles.
  - i_ram_val sampled at T+RD_LAT into the requester's rdata register.
  - rvalid pulses at T+RD_LAT+1 (the RESP cycle).
  - A new grant may coincide with the RESP cycle.
  - Throughput: one read per RD_LAT+1 cycles.
- Fetch halfword select: o_if_rdata = i_if_addr[1] ? word[31:16] : word[15:0], using the address latched at grant.
- Latched at grant: requester id, we and addr[1]. Requesters may change addr/wdata after gnt.
- o_busy = (state == RWAIT).
- Request dropped before grant: legal; nothing is issued.
- Outputs of the non-selected requester: gnt=0, rvalid=0, rdata held.

Decomposition:
- Shared package/defines:
  - RAM_NONE/RAM_READ/RAM_WRITE codes (reuse the existing `RAM_* defines).
  - State encoding ARB_IDLE/ARB_RWAIT/ARB_RESP.
  - Requester id constants REQ_IF=0, REQ_D=1.
- Sub-module arb_starve_pick:
  - Holds the saturating starve counter.
  - Computes the winner from the requests and the counter.
  - Updates the counter on grant.
- Top level holds the FSM, latency counter and response registers.

Test Plan:
- Lone fetch at addr 0x02, RD_LAT=1, RAM word 0xBEEF1234 -> o_if_gnt at T, RAM_READ addr 0x02 at T, o_if_rvalid at T+2 with o_if_rdata=0xBEEF.
- Lone store at addr 0x10, wdata 0xCAFEF00D -> o_d_gnt and RAM_WRITE/0x10/0xCAFEF00D at T; next store granted at T+1; no rvalid.
- Fetch and load both held continuously, MAX_DBURST=4 -> grant order D,D,D,D,IF,D,D,D,D,IF; fetch never waits longer than 4 data grants.
- Back-to-back reads, RD_LAT=3 -> grants at T, T+4, T+8; each rvalid coincides with the next grant cycle; data returned per requester is correct.
- i_rst asserted at T+1 of a load with RD_LAT=2 -> outputs zero asynchronously; no o_d_rvalid; after release, a reissued load completes normally.
- Request withdrawn while another read is in RWAIT -> no RAM access issued for it; o_ram_do=RAM_NONE.
